// File: rtl/vai_rx_demux.sv
// vai_rx_demux: 2-stage CCI-P Rx demux by mdata AFU tag / MMIO window to sub-AFU and manager ports; VAI_RX_DEMUX_STATS_EN adds rsp_count.
package ccip_if_pkg;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_UMSG = 4'h4} t_ccip_c0_rsp;
  typedef enum logic [3:0] {eRSP_WRLINE = 4'h0, eRSP_WRFENCE = 4'h4, eRSP_INTR = 4'h6} t_ccip_c1_rsp;
  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_RspMemHdr;
  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;
  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;
endpackage

module vai_rx_demux
  import ccip_if_pkg::*;
#(
  parameter int NUM_SUB_AFUS  = 7,
  parameter int TAG_LSB       = 12,
  parameter int MMIO_WIN_BITS = 12
) (
  input  logic                           pClk,
  input  logic                           SoftReset_n,
  input  t_if_ccip_Rx                    up_RxPort,
  output t_if_ccip_Rx [NUM_SUB_AFUS-1:0] afu_RxPort,
  output t_if_ccip_Rx                    mgr_RxPort,
  output logic [15:0]                    bad_tag_count
`ifdef VAI_RX_DEMUX_STATS_EN
  ,
  output logic [NUM_SUB_AFUS:0][31:0]    rsp_count
`endif
);
  localparam int NP = NUM_SUB_AFUS + 1;
  localparam logic [15:0] NSUB = 16'(NUM_SUB_AFUS);
  typedef logic [NP-1:0] t_vec;

  t_if_ccip_c0_Rx      s1c0_q, s1c0_d;
  t_if_ccip_c1_Rx      s1c1_q, s1c1_d;
  logic [1:0]          alm_q, alm_d;
  t_ccip_c0_RspMemHdr  hdr0_q, hdr0_d;
  logic [511:0]        data0_q, data0_d;
  t_ccip_c1_RspMemHdr  hdr1_q, hdr1_d;
  t_vec                c0rsp_q, c0rsp_d, mmrd_q, mmrd_d, mmwr_q, mmwr_d, c1rsp_q, c1rsp_d;
  logic [15:0]         bad_q, bad_d;
  logic [15:0]         tag0, tag1, win, mmsel;
  t_ccip_c0_ReqMmioHdr mm;
  logic                umsg, mmio, drop0, drop1;
  logic [16:0]         bad_sum;
  t_if_ccip_Rx [NP-1:0] port_vec;

  // Index NUM_SUB_AFUS of every one-hot vector is the manager port.
  always_comb begin
    s1c0_d  = up_RxPort.c0;
    s1c1_d  = up_RxPort.c1;
    alm_d   = {up_RxPort.c1TxAlmFull, up_RxPort.c0TxAlmFull};
    tag0    = 16'(s1c0_q.hdr.mdata[TAG_LSB+:4]);
    tag1    = 16'(s1c1_q.hdr.mdata[TAG_LSB+:4]);
    umsg    = s1c0_q.hdr.resp_type == eRSP_UMSG;
    mm      = t_ccip_c0_ReqMmioHdr'(s1c0_q.hdr);
    win     = mm.address >> MMIO_WIN_BITS;
    mmio    = s1c0_q.mmioRdValid | s1c0_q.mmioWrValid;
    mmsel   = (win == 16'd0 || win > NSUB) ? NSUB : win - 16'd1;
    hdr0_d  = s1c0_q.hdr;
    if (mmio && win != 16'd0 && win <= NSUB) begin
      mm.address = mm.address & ~(16'hFFFF << MMIO_WIN_BITS);
      hdr0_d     = t_ccip_c0_RspMemHdr'(mm);
    end else if (s1c0_q.rspValid && !umsg && tag0 < NSUB) begin
      hdr0_d.mdata[TAG_LSB+:4] = 4'h0;
    end
    data0_d = s1c0_q.data;
    hdr1_d  = s1c1_q.hdr;
    if (s1c1_q.rspValid && tag1 < NSUB) hdr1_d.mdata[TAG_LSB+:4] = 4'h0;
    c0rsp_d = !s1c0_q.rspValid ? '0 : umsg ? t_vec'(1) << NUM_SUB_AFUS : t_vec'(1) << tag0;
    mmrd_d  = s1c0_q.mmioRdValid ? t_vec'(1) << mmsel : '0;
    mmwr_d  = s1c0_q.mmioWrValid ? t_vec'(1) << mmsel : '0;
    c1rsp_d = s1c1_q.rspValid ? t_vec'(1) << tag1 : '0;
    drop0   = s1c0_q.rspValid && !umsg && tag0 > NSUB;
    drop1   = s1c1_q.rspValid && tag1 > NSUB;
    bad_sum = {1'b0, bad_q} + 17'(drop0) + 17'(drop1);
    bad_d   = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      s1c0_q  <= '0;
      s1c1_q  <= '0;
      alm_q   <= 2'b11;
      hdr0_q  <= '0;
      data0_q <= '0;
      hdr1_q  <= '0;
      c0rsp_q <= '0;
      mmrd_q  <= '0;
      mmwr_q  <= '0;
      c1rsp_q <= '0;
      bad_q   <= '0;
    end else begin
      s1c0_q  <= s1c0_d;
      s1c1_q  <= s1c1_d;
      alm_q   <= alm_d;
      hdr0_q  <= hdr0_d;
      data0_q <= data0_d;
      hdr1_q  <= hdr1_d;
      c0rsp_q <= c0rsp_d;
      mmrd_q  <= mmrd_d;
      mmwr_q  <= mmwr_d;
      c1rsp_q <= c1rsp_d;
      bad_q   <= bad_d;
    end
  end

  // Payload is broadcast; only the valids differ per port.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      port_vec[i].c0TxAlmFull    = alm_q[0];
      port_vec[i].c1TxAlmFull    = alm_q[1];
      port_vec[i].c0.hdr         = hdr0_q;
      port_vec[i].c0.data        = data0_q;
      port_vec[i].c0.rspValid    = c0rsp_q[i];
      port_vec[i].c0.mmioRdValid = mmrd_q[i];
      port_vec[i].c0.mmioWrValid = mmwr_q[i];
      port_vec[i].c1.hdr         = hdr1_q;
      port_vec[i].c1.rspValid    = c1rsp_q[i];
    end
  end

  assign afu_RxPort    = port_vec[NUM_SUB_AFUS-1:0];
  assign mgr_RxPort    = port_vec[NUM_SUB_AFUS];
  assign bad_tag_count = bad_q;

`ifdef VAI_RX_DEMUX_STATS_EN
  logic [NP-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < NP; i++) cnt_d[i] = cnt_q[i] + 32'(c0rsp_d[i] & ~umsg) + 32'(c1rsp_d[i]);
  end

  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  assign rsp_count = cnt_q;
`endif
endmodule

// File: tb/tb_vai_rx_demux.sv
// tb_vai_rx_demux: directed and randomized checks of vai_rx_demux against a spec-level routing model.
module tb_vai_rx_demux;
  import ccip_if_pkg::*;
  localparam int N  = 7;
  localparam int NP = N + 1;

  logic                pClk = 1'b0;
  logic                SoftReset_n = 1'b0;
  t_if_ccip_Rx         up;
  t_if_ccip_Rx [N-1:0] afu;
  t_if_ccip_Rx         mgr;
  logic [15:0]         bad;
`ifdef VAI_RX_DEMUX_STATS_EN
  logic [N:0][31:0]    rsp_count;
`endif
  int checks = 0;
  int failures = 0;

  always #5 pClk = ~pClk;

  vai_rx_demux #(.NUM_SUB_AFUS(N), .TAG_LSB(12), .MMIO_WIN_BITS(12)) dut (
    .pClk(pClk),
    .SoftReset_n(SoftReset_n),
    .up_RxPort(up),
    .afu_RxPort(afu),
    .mgr_RxPort(mgr),
    .bad_tag_count(bad)
`ifdef VAI_RX_DEMUX_STATS_EN
    ,
    .rsp_count(rsp_count)
`endif
  );

  typedef struct {
    logic [NP-1:0]      c0, rd, wr, c1;
    t_ccip_c0_RspMemHdr h0;
    logic [511:0]       d0;
    t_ccip_c1_RspMemHdr h1;
    int                 drops;
    int                 dlv;
  } exp_t;

  task automatic cyc();
    @(posedge pClk);
    #1;
  endtask

  function automatic t_if_ccip_Rx idle();
    t_if_ccip_Rx x;
    x = '0;
    return x;
  endfunction

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32+:32] = $urandom;
    return d;
  endfunction

  function automatic t_if_ccip_Rx mk_c0(t_if_ccip_Rx b, logic [15:0] md, t_ccip_c0_rsp rt);
    t_if_ccip_Rx x;
    x = b;
    x.c0.rspValid      = 1'b1;
    x.c0.hdr.vc_used   = 2'($urandom);
    x.c0.hdr.cl_num    = 2'($urandom);
    x.c0.hdr.resp_type = rt;
    x.c0.hdr.mdata     = md;
    x.c0.data          = rnd_data();
    return x;
  endfunction

  function automatic t_if_ccip_Rx mk_c1(t_if_ccip_Rx b, logic [15:0] md, t_ccip_c1_rsp rt, logic fmt);
    t_if_ccip_Rx x;
    x = b;
    x.c1.rspValid      = 1'b1;
    x.c1.hdr.format    = fmt;
    x.c1.hdr.cl_num    = 2'($urandom);
    x.c1.hdr.resp_type = rt;
    x.c1.hdr.mdata     = md;
    return x;
  endfunction

  function automatic t_if_ccip_Rx mk_mmio(logic wr, logic [15:0] addr, logic [8:0] tid);
    t_if_ccip_Rx x;
    t_ccip_c0_ReqMmioHdr m;
    x = idle();
    m = '0;
    m.address = addr;
    m.tid     = tid;
    m.length  = 2'($urandom);
    x.c0.hdr  = t_ccip_c0_RspMemHdr'(m);
    x.c0.data = rnd_data();
    x.c0.mmioRdValid = !wr;
    x.c0.mmioWrValid = wr;
    return x;
  endfunction

  function automatic t_if_ccip_Rx port(int i);
    if (i == N) return mgr;
    return afu[i];
  endfunction

  function automatic logic [NP-1:0] v_c0();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = port(i).c0.rspValid;
    return v;
  endfunction

  function automatic logic [NP-1:0] v_rd();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = port(i).c0.mmioRdValid;
    return v;
  endfunction

  function automatic logic [NP-1:0] v_wr();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = port(i).c0.mmioWrValid;
    return v;
  endfunction

  function automatic logic [NP-1:0] v_c1();
    logic [NP-1:0] v;
    for (int i = 0; i < NP; i++) v[i] = port(i).c1.rspValid;
    return v;
  endfunction

  function automatic logic [2*NP-1:0] v_alm();
    logic [2*NP-1:0] v;
    for (int i = 0; i < NP; i++) v[2*i+:2] = {port(i).c1TxAlmFull, port(i).c0TxAlmFull};
    return v;
  endfunction

  // Spec-level model: destination by tag (mdata/4096) or MMIO window (address/4096).
  function automatic exp_t model(t_if_ccip_Rx x);
    exp_t e;
    int t, w, d;
    t_ccip_c0_ReqMmioHdr m;
    e.c0 = '0; e.rd = '0; e.wr = '0; e.c1 = '0;
    e.h0 = x.c0.hdr; e.d0 = x.c0.data; e.h1 = x.c1.hdr; e.drops = 0; e.dlv = 0;
    if (x.c0.rspValid) begin
      t = int'(x.c0.hdr.mdata) / 4096;
      if (x.c0.hdr.resp_type == eRSP_UMSG) e.c0[N] = 1'b1;
      else if (t > N) e.drops++;
      else begin
        e.c0[t] = 1'b1;
        e.dlv++;
        if (t < N) e.h0.mdata = x.c0.hdr.mdata % 16'd4096;
      end
    end
    if (x.c0.mmioRdValid || x.c0.mmioWrValid) begin
      m = t_ccip_c0_ReqMmioHdr'(x.c0.hdr);
      w = int'(m.address) / 4096;
      d = (w == 0 || w > N) ? N : w - 1;
      e.rd[d] = x.c0.mmioRdValid;
      e.wr[d] = x.c0.mmioWrValid;
      if (d < N) begin
        m.address = m.address % 16'd4096;
        e.h0 = t_ccip_c0_RspMemHdr'(m);
      end
    end
    if (x.c1.rspValid) begin
      t = int'(x.c1.hdr.mdata) / 4096;
      if (t > N) e.drops++;
      else begin
        e.c1[t] = 1'b1;
        if (t < N) e.h1.mdata = x.c1.hdr.mdata % 16'd4096;
      end
    end
    return e;
  endfunction

  task automatic do_reset();
    SoftReset_n = 1'b0;
    up = idle();
    cyc();
    cyc();
    SoftReset_n = 1'b1;
    cyc();
  endtask

  task automatic send(t_if_ccip_Rx x);
    up = x;
    cyc();
    up = idle();
    cyc();
  endtask

  task automatic test_reset();
    t_if_ccip_Rx x;
    SoftReset_n = 1'b0;
    x = mk_c1(mk_c0(idle(), 16'h1000, eRSP_RDLINE), 16'h2000, eRSP_WRLINE, 1'b0);
    up = x;
    repeat (3) cyc();
    checks += 5;
    if (v_c0() !== '0) begin failures++; $display("FAIL reset_c0: got %b expected 0", v_c0()); end
    if (v_rd() !== '0 || v_wr() !== '0) begin failures++; $display("FAIL reset_mmio: got %b/%b expected 0", v_rd(), v_wr()); end
    if (v_c1() !== '0) begin failures++; $display("FAIL reset_c1: got %b expected 0", v_c1()); end
    if (v_alm() !== '1) begin failures++; $display("FAIL reset_almfull: got %b expected all ones", v_alm()); end
    if (bad !== 16'h0) begin failures++; $display("FAIL reset_bad: got %h expected 0", bad); end
    up = idle();
    SoftReset_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic test_rsp_routing();
    t_if_ccip_Rx x;
    do_reset();
    x = mk_c0(idle(), 16'h30A5, eRSP_RDLINE);
    up = x;
    cyc();
    checks++;
    if (v_c0() !== '0) begin failures++; $display("FAIL lat_early: got %b expected 0", v_c0()); end
    up = idle();
    cyc();
    checks += 3;
    if (v_c0() !== 8'h08) begin failures++; $display("FAIL rd_t3_route: got %b expected 00001000", v_c0()); end
    if (afu[3].c0.hdr.mdata !== 16'h00A5) begin failures++; $display("FAIL rd_t3_mdata: got %h expected 00a5", afu[3].c0.hdr.mdata); end
    if (afu[3].c0.data !== x.c0.data) begin failures++; $display("FAIL rd_t3_data: got %h expected %h", afu[3].c0.data, x.c0.data); end
    send(mk_c1(idle(), 16'h7123, eRSP_WRLINE, 1'b1));
    checks += 2;
    if (v_c1() !== 8'h80) begin failures++; $display("FAIL c1_t7_route: got %b expected 10000000", v_c1()); end
    if (mgr.c1.hdr.mdata !== 16'h7123) begin failures++; $display("FAIL c1_t7_mdata: got %h expected 7123", mgr.c1.hdr.mdata); end
    send(mk_c1(idle(), 16'h9001, eRSP_WRLINE, 1'b0));
    checks += 2;
    if (v_c1() !== '0) begin failures++; $display("FAIL c1_t9_drop: got %b expected 0", v_c1()); end
    if (bad !== 16'd1) begin failures++; $display("FAIL bad_one: got %0d expected 1", bad); end
    send(mk_c1(mk_c0(idle(), 16'hF000, eRSP_RDLINE), 16'hF111, eRSP_WRFENCE, 1'b0));
    checks += 2;
    if (v_c0() !== '0 || v_c1() !== '0) begin failures++; $display("FAIL t15_drop: got %b/%b expected 0", v_c0(), v_c1()); end
    if (bad !== 16'd3) begin failures++; $display("FAIL bad_plus2: got %0d expected 3", bad); end
    send(mk_c0(idle(), 16'h30A5, eRSP_UMSG));
    checks += 2;
    if (v_c0() !== 8'h80) begin failures++; $display("FAIL umsg_route: got %b expected 10000000", v_c0()); end
    if (mgr.c0.hdr.mdata !== 16'h30A5) begin failures++; $display("FAIL umsg_mdata: got %h expected 30a5", mgr.c0.hdr.mdata); end
    send(mk_c1(idle(), 16'h2ABC, eRSP_WRFENCE, 1'b0));
    checks += 2;
    if (v_c1() !== 8'h04) begin failures++; $display("FAIL fence_t2_route: got %b expected 00000100", v_c1()); end
    if (afu[2].c1.hdr.mdata !== 16'h0ABC) begin failures++; $display("FAIL fence_t2_mdata: got %h expected 0abc", afu[2].c1.hdr.mdata); end
  endtask

  task automatic test_mmio();
    t_ccip_c0_ReqMmioHdr m;
    send(mk_mmio(1'b0, 16'h2010, 9'h1A5));
    m = t_ccip_c0_ReqMmioHdr'(afu[1].c0.hdr);
    checks += 4;
    if (v_rd() !== 8'h02) begin failures++; $display("FAIL mmio_w2_route: got %b expected 00000010", v_rd()); end
    if (m.address !== 16'h0010) begin failures++; $display("FAIL mmio_w2_addr: got %h expected 0010", m.address); end
    if (m.tid !== 9'h1A5) begin failures++; $display("FAIL mmio_w2_tid: got %h expected 1a5", m.tid); end
    if (v_c0() !== '0) begin failures++; $display("FAIL mmio_no_rsp: got %b expected 0", v_c0()); end
    send(mk_mmio(1'b0, 16'hF000, 9'h003));
    m = t_ccip_c0_ReqMmioHdr'(mgr.c0.hdr);
    checks += 2;
    if (v_rd() !== 8'h80) begin failures++; $display("FAIL mmio_wf_route: got %b expected 10000000", v_rd()); end
    if (m.address !== 16'hF000) begin failures++; $display("FAIL mmio_wf_addr: got %h expected f000", m.address); end
    send(mk_mmio(1'b1, 16'h0004, 9'h004));
    m = t_ccip_c0_ReqMmioHdr'(mgr.c0.hdr);
    checks += 2;
    if (v_wr() !== 8'h80) begin failures++; $display("FAIL mmio_w0_route: got %b expected 10000000", v_wr()); end
    if (m.address !== 16'h0004) begin failures++; $display("FAIL mmio_w0_addr: got %h expected 0004", m.address); end
    send(mk_mmio(1'b1, 16'h7FFC, 9'h005));
    m = t_ccip_c0_ReqMmioHdr'(afu[6].c0.hdr);
    checks += 2;
    if (v_wr() !== 8'h40) begin failures++; $display("FAIL mmio_w7_route: got %b expected 01000000", v_wr()); end
    if (m.address !== 16'h0FFC) begin failures++; $display("FAIL mmio_w7_addr: got %h expected 0ffc", m.address); end
  endtask

  // 100 cycles of c0 tags 0..7 back to back, then a random mix on both channels.
  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    t_if_ccip_Rx x;
    int exp_bad, exp_dlv, got_dlv, k;
    logic [15:0] md;
    do_reset();
    exp_bad = 0; exp_dlv = 0; got_dlv = 0;
    for (int i = 0; i < 402; i++) begin
      x = idle();
      md = 16'($urandom);
      if (i < 100) x = mk_c0(x, {4'(i % 8), md[11:0]}, eRSP_RDLINE);
      else if (i < 400) begin
        k = $urandom_range(0, 4);
        if (k == 1) x = mk_c0(x, md, eRSP_RDLINE);
        else if (k == 2) x = mk_c0(x, md, eRSP_UMSG);
        else if (k >= 3) x = mk_mmio(k == 4, 16'($urandom), 9'($urandom));
        if ($urandom_range(0, 1) == 1) x = mk_c1(x, 16'($urandom), $urandom_range(0, 1) == 1 ? eRSP_WRFENCE : eRSP_WRLINE, 1'($urandom));
      end
      up = x;
      q.push_back(model(x));
      cyc();
      if (q.size() >= 2) begin
        e = q.pop_front();
        exp_bad = (exp_bad + e.drops > 65535) ? 65535 : exp_bad + e.drops;
        exp_dlv += e.dlv;
        for (int j = 0; j < N; j++) if (v_c0()[j]) got_dlv++;
        if (v_c0()[N] && mgr.c0.hdr.resp_type != eRSP_UMSG) got_dlv++;
        checks += 5;
        if (v_c0() !== e.c0) begin failures++; $display("FAIL stream_c0_route[%0d]: got %b expected %b", i, v_c0(), e.c0); end
        if (v_rd() !== e.rd) begin failures++; $display("FAIL stream_rd_route[%0d]: got %b expected %b", i, v_rd(), e.rd); end
        if (v_wr() !== e.wr) begin failures++; $display("FAIL stream_wr_route[%0d]: got %b expected %b", i, v_wr(), e.wr); end
        if (v_c1() !== e.c1) begin failures++; $display("FAIL stream_c1_route[%0d]: got %b expected %b", i, v_c1(), e.c1); end
        if (bad !== 16'(exp_bad)) begin failures++; $display("FAIL stream_bad[%0d]: got %0d expected %0d", i, bad, exp_bad); end
        if (|(e.c0 | e.rd | e.wr)) begin
          checks += 2;
          if (mgr.c0.hdr !== e.h0) begin failures++; $display("FAIL stream_c0_hdr[%0d]: got %h expected %h", i, mgr.c0.hdr, e.h0); end
          if (mgr.c0.data !== e.d0) begin failures++; $display("FAIL stream_c0_data[%0d]: got %h expected %h", i, mgr.c0.data, e.d0); end
        end
        if (|e.c1) begin
          checks++;
          if (mgr.c1.hdr !== e.h1) begin failures++; $display("FAIL stream_c1_hdr[%0d]: got %h expected %h", i, mgr.c1.hdr, e.h1); end
        end
      end
    end
    checks++;
    if (got_dlv !== exp_dlv) begin failures++; $display("FAIL stream_delivered: got %0d expected %0d", got_dlv, exp_dlv); end
  endtask

  task automatic test_almfull();
    t_if_ccip_Rx x;
    logic a0, a1;
    for (int i = 0; i < 16; i++) begin
      a0 = 1'($urandom);
      a1 = (i % 2) == 0;
      x = idle();
      x.c0TxAlmFull = a0;
      x.c1TxAlmFull = a1;
      up = x;
      cyc();
      checks++;
      if (v_alm() !== {NP{a1, a0}}) begin failures++; $display("FAIL almfull[%0d]: got %b expected %b", i, v_alm(), {NP{a1, a0}}); end
    end
    up = idle();
    cyc();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    up = mk_c1(mk_c0(idle(), 16'h2055, eRSP_RDLINE), 16'hF0AA, eRSP_WRLINE, 1'b0);
    cyc();
    SoftReset_n = 1'b0;
    up = idle();
    #1;
    checks += 2;
    if (v_c0() !== '0 || v_c1() !== '0) begin failures++; $display("FAIL midrst_valids: got %b/%b expected 0", v_c0(), v_c1()); end
    if (v_alm() !== '1) begin failures++; $display("FAIL midrst_almfull: got %b expected all ones", v_alm()); end
    cyc();
    SoftReset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (v_c0() !== '0 || v_c1() !== '0) begin failures++; $display("FAIL midrst_leak[%0d]: got %b/%b expected 0", i, v_c0(), v_c1()); end
    end
    checks++;
    if (bad !== 16'h0) begin failures++; $display("FAIL midrst_bad: got %h expected 0", bad); end
  endtask

  task automatic test_saturation();
    t_if_ccip_Rx x;
    do_reset();
    x = mk_c1(mk_c0(idle(), 16'hF000, eRSP_RDLINE), 16'hA000, eRSP_WRLINE, 1'b0);
    up = x;
    repeat (32767) cyc();
    up = idle();
    cyc();
    cyc();
    checks++;
    if (bad !== 16'hFFFE) begin failures++; $display("FAIL sat_preload: got %h expected fffe", bad); end
    send(x);
    checks++;
    if (bad !== 16'hFFFF) begin failures++; $display("FAIL sat_reach: got %h expected ffff", bad); end
    send(x);
    checks++;
    if (bad !== 16'hFFFF) begin failures++; $display("FAIL sat_hold: got %h expected ffff", bad); end
  endtask

`ifdef VAI_RX_DEMUX_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      up = mk_c0(idle(), 16'h0123, eRSP_RDLINE);
      cyc();
    end
    up = mk_c1(mk_c0(idle(), 16'h1001, eRSP_RDLINE), 16'h1002, eRSP_WRLINE, 1'b0);
    cyc();
    up = mk_c1(idle(), 16'h7000, eRSP_WRLINE, 1'b0);
    cyc();
    up = mk_c1(mk_c0(idle(), 16'h7000, eRSP_UMSG), 16'h7001, eRSP_WRFENCE, 1'b0);
    cyc();
    up = idle();
    cyc();
    cyc();
    checks += 3;
    if (rsp_count[0] !== 32'd5) begin failures++; $display("FAIL stats_afu0: got %0d expected 5", rsp_count[0]); end
    if (rsp_count[1] !== 32'd2) begin failures++; $display("FAIL stats_afu1: got %0d expected 2", rsp_count[1]); end
    if (rsp_count[N] !== 32'd2) begin failures++; $display("FAIL stats_mgr: got %0d expected 2", rsp_count[N]); end
  endtask
`endif

  initial begin
    up = idle();
    test_reset();
    test_rsp_routing();
    test_mmio();
    test_back_to_back();
    test_almfull();
    test_reset_midstream();
`ifdef VAI_RX_DEMUX_STATS_EN
    test_stats();
`endif
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
